traffic_ctrl_np: RTL

- Parametrised N-phase traffic-light controller. It is the successor to the fixed two-road, farm-sensor light controller in the benchmark sequential-circuit set.
- Phase 0 is the main road and is green by default. Side phases 1..N-1 are served round-robin on latched sensor demand.
- Per-state durations are parameters, a side green extends while its demand persists, and a TEST mode bypasses the prescaler.
- It sits between the sensor input registers and the lamp output drivers.

---
 rtl/traffic_pkg.sv | 31 +++
 rtl/traffic_ctrl_np_tick_gen.sv | 32 +++
 rtl/traffic_ctrl_np.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-phase traffic-light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  localparam int MAX_PHASES = 8;

  // Round-robin pick: first pending phase strictly after cur, wrapping.
  // Bits at or above the real phase count must be zero; bit 0 must be set.
  function automatic logic [2:0] next_phase(input logic [MAX_PHASES-1:0] pend,
                                            input logic [2:0] cur);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= MAX_PHASES; i++) begin
      idx = cur + 3'(i);
      if (!found && pend[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/traffic_ctrl_np_tick_gen.sv
// Tick prescaler with a TEST bypass; restart realigns the count to a state entry.
module traffic_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic CK,
  input  logic CLR,
  input  logic TEST,
  input  logic restart,
  output logic TICK
);

  localparam int              CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // The count keeps running under TEST so a mid-state switch back stays aligned.
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      count <= '0;
    end else if (restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  always_comb begin
    TICK = ~CLR & (TEST | (count == LAST));
  end

endmodule

// File: rtl/traffic_ctrl_np.sv
// N-phase traffic-light controller: main road phase 0, side phases served round-robin.
module traffic_ctrl_np
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 3,
  parameter int TIMER_W    = 4,
  parameter int PRESCALE   = 4,
  parameter int GREEN_MIN  = 3,
  parameter int GREEN_MAX  = 6,
  parameter int YELLOW_T   = 2,
  parameter int ALLRED_T   = 1
) (
  input  logic                  CK,
  input  logic                  CLR,
  input  logic                  TEST,
  input  logic [NUM_PHASES-1:0] DEMAND,
  output logic [NUM_PHASES-1:0] GRN,
  output logic [NUM_PHASES-1:0] YLW,
  output logic [NUM_PHASES-1:0] RED,
  output logic [2:0]            PHASE,
  output logic                  TICK
);

  localparam logic [TIMER_W:0] T_ALLRED = (TIMER_W+1)'(ALLRED_T);
  localparam logic [TIMER_W:0] T_YELLOW = (TIMER_W+1)'(YELLOW_T);
  localparam logic [TIMER_W:0] T_GMIN   = (TIMER_W+1)'(GREEN_MIN);
  localparam logic [TIMER_W:0] T_GMAX   = (TIMER_W+1)'(GREEN_MAX);

  state_t                  state;
  state_t                  state_nxt;
  logic [2:0]              phase;
  logic [2:0]              phase_nxt;
  logic [TIMER_W-1:0]      timer;
  logic [TIMER_W:0]        t_elapsed;
  logic [NUM_PHASES-1:0]   pend;
  logic [NUM_PHASES-1:0]   pend_nxt;
  logic [MAX_PHASES-1:0]   pend_ext;
  logic [MAX_PHASES-1:0]   demand_ext;
  logic                    tick;
  logic                    leave;

  traffic_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .CK      (CK),
    .CLR     (CLR),
    .TEST    (TEST),
    .restart (leave),
    .TICK    (tick)
  );

  assign TICK       = tick;
  assign t_elapsed  = {1'b0, timer} + (TIMER_W+1)'(1);
  assign pend_ext   = MAX_PHASES'(pend) | MAX_PHASES'(1);
  assign demand_ext = MAX_PHASES'(DEMAND);

  // State and phase register.
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      state <= ALLRED;
      phase <= 3'd0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  // Next-state logic; transitions are evaluated only on tick cycles.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    leave     = 1'b0;
    if (tick) begin
      case (state)
        ALLRED: begin
          if (t_elapsed == T_ALLRED) begin
            state_nxt = GREEN;
            phase_nxt = next_phase(pend_ext, phase);
            leave     = 1'b1;
          end else begin
            leave     = 1'b0;
          end
        end
        GREEN: begin
          if (phase == 3'd0) begin
            leave = (t_elapsed >= T_GMIN) && (|pend_ext[MAX_PHASES-1:1]);
          end else begin
            leave = (t_elapsed >= T_GMAX) ||
                    ((t_elapsed >= T_GMIN) && !demand_ext[phase]);
          end
          if (leave) begin
            state_nxt = YELLOW;
          end else begin
            state_nxt = GREEN;
          end
        end
        YELLOW: begin
          if (t_elapsed == T_YELLOW) begin
            state_nxt = ALLRED;
            leave     = 1'b1;
          end else begin
            leave     = 1'b0;
          end
        end
        default: begin
          state_nxt = ALLRED;
          phase_nxt = 3'd0;
          leave     = 1'b1;
        end
      endcase
    end else begin
      leave = 1'b0;
    end
  end

  // State timer: cleared on every transition, saturating tick count otherwise.
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      timer <= '0;
    end else if (leave) begin
      timer <= '0;
    end else if (tick && (timer != '1)) begin
      timer <= timer + TIMER_W'(1);
    end else begin
      timer <= timer;
    end
  end

  // Clearing on green entry deliberately overrides a same-cycle request.
  always_comb begin
    pend_nxt = pend | DEMAND;
    if ((state == ALLRED) && leave) begin
      pend_nxt = pend_nxt & ~(NUM_PHASES'(1) << phase_nxt);
    end else begin
      pend_nxt = pend_nxt;
    end
    pend_nxt[0] = 1'b0;
  end

  // Pending-demand register.
  always_ff @(posedge CK or posedge CLR) begin
    if (CLR) begin
      pend <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  // Lamp decode from the state and phase registers only.
  always_comb begin
    GRN   = '0;
    YLW   = '0;
    PHASE = phase;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase == 3'(i)) begin
        GRN[i] = (state == GREEN);
        YLW[i] = (state == YELLOW);
      end else begin
        GRN[i] = 1'b0;
        YLW[i] = 1'b0;
      end
    end
    RED = ~(GRN | YLW);
  end

endmodule
